uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receiver-side byte capture with rdy/clr handshake, FIFO buffering and overrun counting.
// Optional idle timeout pulse enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 5208
) (
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     rx_rdy_clr,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               overrun_cnt,
  output logic                     rx_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT_CLR} state_t;

  state_t        r_state;
  logic          r_rx_rdy_clr;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_ovr;

  logic w_cap, w_pop, w_space, w_push, w_drop;

  assign w_cap   = (r_state == IDLE) && en && rx_rdy;
  assign w_pop   = m_valid && m_ready;
  // A full FIFO still accepts the byte when the head leaves on the same edge.
  assign w_space = (r_count < CW'(DEPTH)) || w_pop;
  assign w_push  = w_cap && w_space && !flush;
  assign w_drop  = w_cap && !w_space && !flush;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rx_rdy_clr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_cap) begin
          r_rx_rdy_clr <= 1'b1;
          r_state      <= WAIT_CLR;
        end
        WAIT_CLR: if (!rx_rdy) begin
          r_rx_rdy_clr <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)                      r_ovr <= '0;
    else if (w_drop && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
  end

  assign rx_rdy_clr  = r_rx_rdy_clr;
  assign m_valid     = (r_count != '0);
  assign m_data      = m_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count  = r_count;
  assign overrun_cnt = r_ovr;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_to_fired;
  logic          r_timeout;

  // After firing the counter parks until the next capture re-arms it.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_cap || flush) begin
      r_to_cnt   <= '0;
      r_to_fired <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (r_count != '0 && !r_to_fired) begin
      if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        r_timeout  <= 1'b1;
        r_to_fired <= 1'b1;
      end else begin
        r_to_cnt  <= r_to_cnt + TW'(1);
        r_timeout <= 1'b0;
      end
    end else begin
      r_timeout <= 1'b0;
    end
  end

  assign rx_timeout = r_timeout;
`else
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for basic handshake/FIFO behaviour,
// hand sequences for fill/overrun, full-with-pop, reset mid-handshake, flush and timeout.
module tb_uart_rx_ctrl;
  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, flush = 1'b0, rx_rdy = 1'b0, m_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy_clr, m_valid, rx_timeout;
  logic [7:0] m_data, overrun_cnt;
  logic [3:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int to_seen = 0;

  uart_rx_ctrl #(.DEPTH(8), .TIMEOUT_CYC(16)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .en(en), .flush(flush),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fifo_count(fifo_count), .overrun_cnt(overrun_cnt), .rx_timeout(rx_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) if (rx_timeout === 1'b1) to_seen++;

  typedef struct {
    logic       en, fl, rdy;
    logic [7:0] d;
    logic       mr;
    logic       clr, v;
    logic [7:0] md;
    logic [3:0] cnt;
    logic [7:0] ovr;
  } vec_t;

  vec_t vt [13];
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input string nm);
    en = 1'b1; rx_rdy = 1'b1; rx_data = d;
    tick();
    chk({nm, ".clr_hi"}, rx_rdy_clr, 1'b1);
    rx_rdy = 1'b0;
    tick();
    chk({nm, ".clr_lo"}, rx_rdy_clr, 1'b0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.v%0d", nm, i), m_valid, 1'b1);
      chk($sformatf("%s.d%0d", nm, i), m_data, exp_q[i]);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    exp_q.delete();
    chk({nm, ".empty"}, fifo_count, 4'd0);
    chk({nm, ".v_end"}, m_valid, 1'b0);
  endtask

  initial begin
    int pulses, hit_k;
    //          en  fl  rdy  d      mr   clr v   md     cnt ovr
    vt[0]  = '{1'b1,1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b1,8'hA5,4'd1,8'd0};
    vt[1]  = '{1'b1,1'b0,1'b1,8'hA5,1'b1, 1'b1,1'b0,8'h00,4'd0,8'd0};
    vt[2]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,4'd0,8'd0};
    vt[3]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,4'd0,8'd0};
    vt[4]  = '{1'b0,1'b0,1'b1,8'h3C,1'b0, 1'b0,1'b0,8'h00,4'd0,8'd0};
    vt[5]  = '{1'b1,1'b0,1'b1,8'h3C,1'b0, 1'b1,1'b1,8'h3C,4'd1,8'd0};
    vt[6]  = '{1'b0,1'b0,1'b1,8'h3C,1'b0, 1'b1,1'b1,8'h3C,4'd1,8'd0};
    vt[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h3C,4'd1,8'd0};
    vt[8]  = '{1'b1,1'b0,1'b1,8'h7E,1'b0, 1'b1,1'b1,8'h3C,4'd2,8'd0};
    vt[9]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h7E,4'd1,8'd0};
    vt[10] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,4'd0,8'd0};
    vt[11] = '{1'b1,1'b1,1'b1,8'h11,1'b0, 1'b1,1'b0,8'h00,4'd0,8'd0};
    vt[12] = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,4'd0,8'd0};

    // reset state
    tick(); tick();
    chk("rst.clr", rx_rdy_clr, 1'b0);
    chk("rst.v",   m_valid, 1'b0);
    chk("rst.md",  m_data, 8'h00);
    chk("rst.cnt", fifo_count, 4'd0);
    chk("rst.ovr", overrun_cnt, 8'd0);
    chk("rst.to",  rx_timeout, 1'b0);
    #4 rst_n = 1'b1;

    // table: single byte, en gating, en drop during ack, push/pop, flush+capture
    for (int i = 0; i < 13; i++) begin
      en = vt[i].en; flush = vt[i].fl; rx_rdy = vt[i].rdy;
      rx_data = vt[i].d; m_ready = vt[i].mr;
      tick();
      chk($sformatf("vec%0d.clr", i), rx_rdy_clr,  vt[i].clr);
      chk($sformatf("vec%0d.v",   i), m_valid,     vt[i].v);
      chk($sformatf("vec%0d.md",  i), m_data,      vt[i].md);
      chk($sformatf("vec%0d.cnt", i), fifo_count,  vt[i].cnt);
      chk($sformatf("vec%0d.ovr", i), overrun_cnt, vt[i].ovr);
    end
    flush = 1'b0; m_ready = 1'b0;

    // fill past full: 10 bytes, last two dropped
    for (int i = 1; i <= 10; i++) begin
      send_byte(8'(i), $sformatf("fill%0d", i));
      if (i <= 8) exp_q.push_back(8'(i));
    end
    chk("fill.cnt", fifo_count, 4'd8);
    chk("fill.ovr", overrun_cnt, 8'd2);
    drain("fill_drain");

    // full FIFO accepts a capture when the head pops on the same edge
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h21 + 8'(i), $sformatf("full%0d", i));
      exp_q.push_back(8'h21 + 8'(i));
    end
    chk("full.cnt", fifo_count, 4'd8);
    rx_rdy = 1'b1; rx_data = 8'h55; m_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    tick();
    chk("fullpop.cnt", fifo_count, 4'd8);
    chk("fullpop.ovr", overrun_cnt, 8'd2);
    chk("fullpop.md",  m_data, 8'h22);
    rx_rdy = 1'b0; m_ready = 1'b0;
    tick();
    drain("fullpop_drain");

    // reset during WAIT_CLR with rx_rdy held high
    rx_rdy = 1'b1; rx_data = 8'h9A;
    tick();
    chk("rmid.clr_pre", rx_rdy_clr, 1'b1);
    #4 rst_n = 1'b0;
    #1;
    chk("rmid.clr", rx_rdy_clr, 1'b0);
    chk("rmid.v",   m_valid, 1'b0);
    chk("rmid.md",  m_data, 8'h00);
    chk("rmid.cnt", fifo_count, 4'd0);
    chk("rmid.ovr", overrun_cnt, 8'd0);
    chk("rmid.to",  rx_timeout, 1'b0);
    tick();
    #4 rst_n = 1'b1;
    tick();
    chk("rrel.clr", rx_rdy_clr, 1'b1);
    chk("rrel.cnt", fifo_count, 4'd1);
    chk("rrel.md",  m_data, 8'h9A);
    tick();
    chk("rrel.once", fifo_count, 4'd1);
    rx_rdy = 1'b0;
    tick();
    chk("rrel.clr_lo", rx_rdy_clr, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rrel.flush", fifo_count, 4'd0);

    // flush with concurrent capture: nothing queued, nothing counted
    send_byte(8'hB1, "fl1");
    send_byte(8'hB2, "fl2");
    send_byte(8'hB3, "fl3");
    chk("fl.cnt3", fifo_count, 4'd3);
    rx_rdy = 1'b1; rx_data = 8'hB4; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.cnt", fifo_count, 4'd0);
    chk("fl.v",   m_valid, 1'b0);
    chk("fl.ovr", overrun_cnt, 8'd0);
    chk("fl.clr", rx_rdy_clr, 1'b1);
    rx_rdy = 1'b0;
    tick();

    // idle timeout after a single byte
    rx_rdy = 1'b1; rx_data = 8'h44; m_ready = 1'b0;
    tick();
    rx_rdy = 1'b0;
    pulses = 0; hit_k = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rx_timeout === 1'b1) begin
        pulses++;
        hit_k = k;
      end
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    chk("to.pulses", pulses, 1);
    chk("to.cycle",  hit_k, 16);
`else
    chk("to.pulses", pulses, 0);
    chk("to.never",  to_seen, 0);
`endif
    chk("to.cnt", fifo_count, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
